mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 select mux among four requesters. It owns the mux select: it grants one requester at a time and drives the registered select. The selected requester's data lane is routed to a single output. A hold limit stops any one requester from starving the others. It sits in front of the 4:1 mux datapath and replaces free-running select stimulus with sequenced ownership.

Parameters:
WIDTH, 1, bit width of each requester data lane and of out_data
MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 2..256

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i
data  input  4*WIDTH  packed lanes; lane i = data[i*WIDTH +: WIDTH]
grant  output  4  one-hot grant, registered; all zero when no owner
sel  output  2  registered mux select; index of current owner
out_valid  output  1  registered; high while an owner is granted
out_data  output  WIDTH  data[sel] when out_valid, else all zero (combinational from sel)

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-grant):
  - grant=0, sel=0, out_valid=0, out_data=0.
  - State IDLE, last-owner pointer=3, hold_cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick a winner by round-robin search starting at last+1 mod 4.
  - Next edge: grant=onehot(winner), sel=winner, out_valid=1, hold_cnt=0, go to GRANT.
  - Latency is 1 cycle from req seen high to grant high.
- GRANT: the owner keeps the grant while req[owner]=1 and hold_cnt < MAX_HOLD-1. hold_cnt increments each such cycle.
- Release occurs when req[owner]=0 or hold_cnt = MAX_HOLD-1. On the release edge:
  - last=owner.
  - Re-arbitrate over the current req vector, searching from owner+1 mod 4.
  - If a winner exists, grant it on that same edge with hold_cnt=0, giving a back-to-back handover with no idle cycle.
  - If no winner exists: grant=0, out_valid=0, sel holds its value, go to IDLE.
- Hold expiry with only the owner requesting: the search wraps back to the owner. The owner is re-granted with hold_cnt=0; grant stays high continuously.
- Simultaneous requests: exactly one winner, the first set bit at or after last+1 mod 4.
- grant is always one-hot or zero. sel changes only on a grant edge.
- A requester dropping req while not owner has no effect. Requests are level-sensitive, not latched.
- out_data tracks data[sel] combinationally with zero latency from data.

Optional Feature:
MUX_ARB_FIXED_PRIO_EN
- Defined: fixed priority replaces round-robin. The search always starts at index 0, so the lowest index wins. The last pointer is ignored. MAX_HOLD still forces release; after expiry, a higher-priority requester still pending wins the next grant.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then req=4'b0000 -> grant=0, sel=0, out_valid=0, out_data=0 for 5 cycles.
- req=4'b0101 from IDLE after reset, data lanes = 0,1,0,1 (WIDTH=1) -> one cycle later grant=0001, sel=0, out_data=0. Drop req[0] -> next edge grant=0100, sel=2, out_data=0, no idle cycle.
- req=4'b1111 held for 40 cycles, MAX_HOLD=8 -> grants rotate 0001,0010,0100,1000, each exactly 8 cycles; sel follows 0,1,2,3.
- Only req[2]=1 held for 20 cycles, MAX_HOLD=8 -> grant=0100 continuously, out_valid never drops.
- rst_n pulsed low mid-grant (owner=1, hold_cnt=3) -> grant=0, out_valid=0 without waiting for clk. After release with req=4'b0010, grant=0010 one cycle later.
- With MUX_ARB_FIXED_PRIO_EN defined and req=4'b1001 held -> requester 0 granted; after 8 cycles it is re-granted; requester 3 is granted only once req[0] drops.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: shares one 4:1 select mux among four requesters.
// The arbiter owns the mux select. It grants one requester at a time, with a
// hold limit so that no requester can starve the others. The owner's data lane
// is routed to out_data.
//
// Optional build macro MUX_ARB_FIXED_PRIO_EN: when defined, the winner search
// always starts at index 0, so the lowest index wins (fixed priority). The
// hold limit still forces a release. When the macro is undefined, the search
// starts one past the last owner (round robin).
//
// Handshake: req is level-sensitive and is never latched. A requester owns the
// mux from the edge that raises its grant bit. It keeps ownership while its req
// stays high and the hold limit is not reached. A requester that drops req while
// it is not the owner has no effect on the arbiter.
module mux_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    output logic [3:0]         grant,
    output logic [1:0]         sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               dbg_state
);

    // Hold counter only has to reach MAX_HOLD-1.
    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [3:0]      grant_q;
    logic [1:0]      sel_q;
    logic            valid_q;
    logic [CW-1:0]   hold_cnt_q;
    logic [CW-1:0]   hold_cnt_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
    logic [1:0]      last_q;
`endif

    logic [1:0]      idle_start;
    logic [1:0]      rel_start;
    logic            idle_found;
    logic [1:0]      idle_idx;
    logic            rel_found;
    logic [1:0]      rel_idx;
    logic            keep_owner;

    // Returns the first set request at or after 'start', wrapping mod 4.
    function automatic logic [2:0] pick_first(input logic [3:0] r, input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = start + 2'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Select the search start points, then find the winners for the idle case
    // and for the release case.
    always_comb begin
`ifdef MUX_ARB_FIXED_PRIO_EN
        idle_start = 2'd0;
        rel_start  = 2'd0;
`else
        idle_start = last_q + 2'd1;
        rel_start  = sel_q + 2'd1;
`endif
        {idle_found, idle_idx} = pick_first(req, idle_start);
        {rel_found, rel_idx}   = pick_first(req, rel_start);
        keep_owner = req[sel_q] && (hold_cnt_q != HOLD_LAST);
        hold_cnt_d = hold_cnt_q + 1'b1;
    end

    // Ownership FSM. It registers the grant, the select and the valid output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= 4'b0000;
            sel_q      <= 2'd0;
            valid_q    <= 1'b0;
            hold_cnt_q <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_q     <= 2'd3;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (idle_found) begin
                        grant_q    <= 4'b0001 << idle_idx;
                        sel_q      <= idle_idx;
                        valid_q    <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (keep_owner) begin
                        hold_cnt_q <= hold_cnt_d;
                    end else begin
`ifndef MUX_ARB_FIXED_PRIO_EN
                        last_q <= sel_q;
`endif
                        hold_cnt_q <= '0;
                        if (rel_found) begin
                            // Back-to-back handover. This can re-grant the same owner.
                            grant_q <= 4'b0001 << rel_idx;
                            sel_q   <= rel_idx;
                            valid_q <= 1'b1;
                        end else begin
                            // sel keeps its value while the arbiter is idle.
                            grant_q <= 4'b0000;
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Route the owner's lane to the output. The output is zero when no one owns the mux.
    always_comb begin
        out_data = '0;
        if (valid_q) begin
            out_data = data[sel_q*WIDTH +: WIDTH];
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter (WIDTH=1, MAX_HOLD=8).
// Build with MUX_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
`timescale 1ns/1ps
module tb_mux_rr_arbiter;

  localparam int WIDTH    = 1;
  localparam int MAX_HOLD = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data;
  logic [3:0]         grant;
  logic [1:0]         sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               dbg_state;

  int n_checks;
  int n_fail;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // checker
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic d);
    check_eq({tag, "_grant"}, 32'(grant), 32'(g));
    check_eq({tag, "_sel"}, 32'(sel), 32'(s));
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
    check_eq({tag, "_data"}, 32'(out_data), 32'(d));
  endtask

  // drivers
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_idx;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    data     = 4'b1010;   // lanes 0,1,0,1

    // reset state, idle with no requests
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all("reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // two requesters from idle, then a handover when the owner drops
    req = 4'b0101;
    @(negedge clk);
    check_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0100;
    @(negedge clk);
    check_all("handover", 4'b0100, 2'd2, 1'b1, 1'b0);
    data = 4'b0100;       // lane 2 goes high, and out_data must follow it without a clock
    #1;
    check_eq("comb_data", 32'(out_data), 32'd1);
    data = 4'b1010;
    #1;
    check_eq("comb_data_back", 32'(out_data), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    check_all("release_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // all requesting: each grant lasts exactly MAX_HOLD cycles
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
`ifdef MUX_ARB_FIXED_PRIO_EN
      exp_idx = 2'd0;
`else
      exp_idx = 2'((k / MAX_HOLD) % 4);
`endif
      check_eq("rotate_grant", 32'(grant), 32'(4'b0001 << exp_idx));
      check_eq("rotate_sel", 32'(sel), 32'(exp_idx));
    end

    // a lone requester keeps its grant continuously through each hold expiry
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("solo_grant", 32'(grant), 32'(4'b0100));
      check_eq("solo_valid", 32'(out_valid), 32'd1);
    end

    // asynchronous reset during a grant (owner 1, hold_cnt 3)
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    check_eq("pre_rst_grant", 32'(grant), 32'(4'b0010));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_grant", 32'(grant), 32'd0);
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_rst", 4'b0010, 2'd1, 1'b1, 1'b1);

    // requesters 0 and 3 compete
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
`ifdef MUX_ARB_FIXED_PRIO_EN
      exp_idx = 2'd0;
`else
      exp_idx = (k < MAX_HOLD) ? 2'd0 : 2'd3;
`endif
      check_eq("pair_grant", 32'(grant), 32'(4'b0001 << exp_idx));
    end
    req = 4'b1000;
    @(negedge clk);
    check_all("pair_after_drop", 4'b1000, 2'd3, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
